// File: rtl/trap_commit_if.sv
// Pipeline <-> trap commit bundle: trap/return requests, CSR write bus,
// redirect back to the IFU and the committed trap CSR state.
//
// master : pipeline side (drives requests, reads redirect and CSR state)
// slave  : trap_commit (consumes requests, drives redirect and CSR state)
//
//  StallW        hold, no state update this cycle
//  TrapM         trap taken this cycle
//  InterruptM    trap is an interrupt
//  DelegateM     trap handled in S-mode
//  CauseM        trap cause code
//  PCM           PC of the trapping/returning instruction
//  TvalM         fault value for exceptions
//  mretM/sretM   return instructions in M stage
//  MTVEC/STVEC   trap vector CSRs
//  CSRWriteM     CSR write strobe, CSRAdrM address, CSRWriteValM data
//  RedirectM     PC redirect required, RedirectPCM target
//  PrivilegeModeW, STATUS_*, xEPC/xCAUSE/xTVAL  committed state
interface trap_commit_if #(
    parameter int XLEN = 64
);
    logic            StallW;
    logic            TrapM;
    logic            InterruptM;
    logic            DelegateM;
    logic [4:0]      CauseM;
    logic [XLEN-1:0] PCM;
    logic [XLEN-1:0] TvalM;
    logic            mretM;
    logic            sretM;
    logic [XLEN-1:0] MTVEC;
    logic [XLEN-1:0] STVEC;
    logic            CSRWriteM;
    logic [11:0]     CSRAdrM;
    logic [XLEN-1:0] CSRWriteValM;

    logic            RedirectM;
    logic [XLEN-1:0] RedirectPCM;
    logic [1:0]      PrivilegeModeW;
    logic            STATUS_MIE;
    logic            STATUS_SIE;
    logic            STATUS_MPIE;
    logic            STATUS_SPIE;
    logic            STATUS_SPP;
    logic            STATUS_MPRV;
    logic [1:0]      STATUS_MPP;
    logic [XLEN-1:0] MEPC;
    logic [XLEN-1:0] MCAUSE;
    logic [XLEN-1:0] MTVAL;
    logic [XLEN-1:0] SEPC;
    logic [XLEN-1:0] SCAUSE;
    logic [XLEN-1:0] STVAL;

    modport master (
        output StallW, TrapM, InterruptM, DelegateM, CauseM,
        output PCM, TvalM, mretM, sretM, MTVEC, STVEC,
        output CSRWriteM, CSRAdrM, CSRWriteValM,
        input  RedirectM, RedirectPCM, PrivilegeModeW,
        input  STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE,
        input  STATUS_SPP, STATUS_MPRV, STATUS_MPP,
        input  MEPC, MCAUSE, MTVAL, SEPC, SCAUSE, STVAL
    );

    modport slave (
        input  StallW, TrapM, InterruptM, DelegateM, CauseM,
        input  PCM, TvalM, mretM, sretM, MTVEC, STVEC,
        input  CSRWriteM, CSRAdrM, CSRWriteValM,
        output RedirectM, RedirectPCM, PrivilegeModeW,
        output STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE,
        output STATUS_SPP, STATUS_MPRV, STATUS_MPP,
        output MEPC, MCAUSE, MTVAL, SEPC, SCAUSE, STVAL
    );
endinterface

// File: rtl/trap_commit.sv
// Trap commit: applies trap entry, mret and sret to privilege mode, the
// MSTATUS interrupt stack and the M/S trap CSRs; drives the IFU redirect.
//
// Ports:
//  clk    clock
//  reset  synchronous, active-high
//  tc     trap_commit_if.slave (requests in, redirect and CSR state out)
module trap_commit #(
    parameter int XLEN        = 64,
    parameter int S_SUPPORTED = 1,
    parameter int U_SUPPORTED = 1,
    parameter int C_SUPPORTED = 1
) (
    input  logic          clk,
    input  logic          reset,
    trap_commit_if.slave  tc
);
    localparam bit HAS_S = (S_SUPPORTED != 0);
    localparam bit HAS_U = (U_SUPPORTED != 0);
    localparam bit HAS_C = (C_SUPPORTED != 0);

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Lowest mode an mret can drop to, also the reset value of MPP.
    localparam logic [1:0] MPP_LOW = HAS_U ? PRIV_U : PRIV_M;

    localparam logic [XLEN-1:0] CAUSE_KEEP =
        {1'b1, {(XLEN-6){1'b0}}, 5'h1f};

    localparam logic [11:0] A_SSTATUS = 12'h100;
    localparam logic [11:0] A_SEPC    = 12'h141;
    localparam logic [11:0] A_SCAUSE  = 12'h142;
    localparam logic [11:0] A_STVAL   = 12'h143;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    // mstatus bit positions
    localparam int B_SIE  = 1;
    localparam int B_MIE  = 3;
    localparam int B_SPIE = 5;
    localparam int B_MPIE = 7;
    localparam int B_SPP  = 8;
    localparam int B_MPP  = 11;
    localparam int B_MPRV = 17;

    logic [1:0]      priv;
    logic            mie;
    logic            sie;
    logic            mpie;
    logic            spie;
    logic            spp;
    logic            mprv;
    logic [1:0]      mpp;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] sepc;
    logic [XLEN-1:0] scause;
    logic [XLEN-1:0] stval;

    logic [1:0]      nxt_priv;
    logic            nxt_mie;
    logic            nxt_sie;
    logic            nxt_mpie;
    logic            nxt_spie;
    logic            nxt_spp;
    logic            nxt_mprv;
    logic [1:0]      nxt_mpp;
    logic [XLEN-1:0] nxt_mepc;
    logic [XLEN-1:0] nxt_mcause;
    logic [XLEN-1:0] nxt_mtval;
    logic [XLEN-1:0] nxt_sepc;
    logic [XLEN-1:0] nxt_scause;
    logic [XLEN-1:0] nxt_stval;

    logic            to_s;
    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] wval;

    function automatic logic [XLEN-1:0] epc_mask(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        r[0] = 1'b0;
        if (!HAS_C) r[1] = 1'b0;
        return r;
    endfunction

    // Illegal MPP encodings leave the field untouched.
    function automatic logic [1:0] legal_mpp(
        input logic [1:0] req,
        input logic [1:0] old
    );
        logic [1:0] r;
        r = old;
        case (req)
            PRIV_M:  r = req;
            PRIV_S:  r = HAS_S ? req : old;
            PRIV_U:  r = HAS_U ? req : old;
            default: r = old;
        endcase
        return r;
    endfunction

    // Without S-mode every trap lands in M regardless of DelegateM.
    assign to_s = tc.DelegateM & HAS_S;

    assign tvec = to_s ? tc.STVEC : tc.MTVEC;
    assign base = {tvec[XLEN-1:2], 2'b00};

    // Only mode 01 vectors, and only for interrupts.
    always_comb begin
        vec = base;
        if (tvec[1:0] == 2'b01 && tc.InterruptM)
            vec = base + {{(XLEN-7){1'b0}}, tc.CauseM, 2'b00};
    end

    assign tc.RedirectM = tc.TrapM | tc.mretM | tc.sretM;

    always_comb begin
        tc.RedirectPCM = '0;
        if (tc.TrapM)
            tc.RedirectPCM = vec;
        else if (tc.mretM)
            tc.RedirectPCM = mepc;
        else if (tc.sretM)
            tc.RedirectPCM = sepc;
    end

    assign trap_cause = {tc.InterruptM, {(XLEN-6){1'b0}}, tc.CauseM};
    assign trap_tval  = tc.InterruptM ? '0 : tc.TvalM;
    assign trap_epc   = epc_mask(tc.PCM);
    assign wval       = tc.CSRWriteValM;

    always_comb begin
        nxt_priv   = priv;
        nxt_mie    = mie;
        nxt_sie    = sie;
        nxt_mpie   = mpie;
        nxt_spie   = spie;
        nxt_spp    = spp;
        nxt_mprv   = mprv;
        nxt_mpp    = mpp;
        nxt_mepc   = mepc;
        nxt_mcause = mcause;
        nxt_mtval  = mtval;
        nxt_sepc   = sepc;
        nxt_scause = scause;
        nxt_stval  = stval;

        if (tc.TrapM) begin
            if (to_s) begin
                nxt_sepc   = trap_epc;
                nxt_scause = trap_cause;
                nxt_stval  = trap_tval;
                nxt_spie   = sie;
                nxt_sie    = 1'b0;
                nxt_spp    = priv[0];
                nxt_priv   = PRIV_S;
            end else begin
                nxt_mepc   = trap_epc;
                nxt_mcause = trap_cause;
                nxt_mtval  = trap_tval;
                nxt_mpie   = mie;
                nxt_mie    = 1'b0;
                nxt_mpp    = priv;
                nxt_priv   = PRIV_M;
            end
        end else if (tc.mretM) begin
            nxt_priv = mpp;
            nxt_mie  = mpie;
            nxt_mpie = 1'b1;
            nxt_mpp  = MPP_LOW;
            if (mpp != PRIV_M) nxt_mprv = 1'b0;
        end else if (tc.sretM) begin
            // sret cannot be a valid instruction without S-mode.
            if (HAS_S) begin
                nxt_priv = {1'b0, spp};
                nxt_sie  = spie;
                nxt_spie = 1'b1;
                nxt_spp  = 1'b0;
                nxt_mprv = 1'b0;
            end
        end else if (tc.CSRWriteM) begin
            case (tc.CSRAdrM)
                A_MSTATUS: begin
                    nxt_mie  = wval[B_MIE];
                    nxt_mpie = wval[B_MPIE];
                    nxt_mprv = wval[B_MPRV];
                    nxt_mpp  = legal_mpp(wval[B_MPP+:2], mpp);
                    if (HAS_S) begin
                        nxt_sie  = wval[B_SIE];
                        nxt_spie = wval[B_SPIE];
                        nxt_spp  = wval[B_SPP];
                    end
                end
                A_SSTATUS: begin
                    if (HAS_S) begin
                        nxt_sie  = wval[B_SIE];
                        nxt_spie = wval[B_SPIE];
                        nxt_spp  = wval[B_SPP];
                    end
                end
                A_MEPC:   nxt_mepc   = epc_mask(wval);
                A_MCAUSE: nxt_mcause = wval & CAUSE_KEEP;
                A_MTVAL:  nxt_mtval  = wval;
                A_SEPC:   if (HAS_S) nxt_sepc   = epc_mask(wval);
                A_SCAUSE: if (HAS_S) nxt_scause = wval & CAUSE_KEEP;
                A_STVAL:  if (HAS_S) nxt_stval  = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            priv   <= PRIV_M;
            mie    <= 1'b0;
            sie    <= 1'b0;
            mpie   <= 1'b0;
            spie   <= 1'b0;
            spp    <= 1'b0;
            mprv   <= 1'b0;
            mpp    <= MPP_LOW;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
            sepc   <= '0;
            scause <= '0;
            stval  <= '0;
        end else if (!tc.StallW) begin
            priv   <= nxt_priv;
            mie    <= nxt_mie;
            sie    <= nxt_sie;
            mpie   <= nxt_mpie;
            spie   <= nxt_spie;
            spp    <= nxt_spp;
            mprv   <= nxt_mprv;
            mpp    <= nxt_mpp;
            mepc   <= nxt_mepc;
            mcause <= nxt_mcause;
            mtval  <= nxt_mtval;
            sepc   <= nxt_sepc;
            scause <= nxt_scause;
            stval  <= nxt_stval;
        end
    end

    assign tc.PrivilegeModeW = priv;
    assign tc.STATUS_MIE     = mie;
    assign tc.STATUS_SIE     = sie;
    assign tc.STATUS_MPIE    = mpie;
    assign tc.STATUS_SPIE    = spie;
    assign tc.STATUS_SPP     = spp;
    assign tc.STATUS_MPRV    = mprv;
    assign tc.STATUS_MPP     = mpp;
    assign tc.MEPC           = mepc;
    assign tc.MCAUSE         = mcause;
    assign tc.MTVAL          = mtval;
    assign tc.SEPC           = sepc;
    assign tc.SCAUSE         = scause;
    assign tc.STVAL          = stval;
endmodule
